dsss_spreader: RTL and testbench

//  Direct-sequence spreader directly downstream of the Gold code generator.
//  - Accepts one data bit per symbol on a valid/ready input.
//  - Drives the generator's chip request (its tvalid input) and XORs each returned Gold chip with the held bit.
//  - Emits N chips per bit on a valid/ready output with full backpressure.
//  - The generator's phase is never reset by this block; the code runs continuously across symbols.

---
 rtl/dsss_pkg.sv | 18 +
 rtl/dsss_spreader_skid.sv | 54 +++++
 rtl/dsss_spreader.sv | 122 ++++++++++++
 tb/tb_dsss_spreader.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsss_pkg.sv
// Shared types and constants for the DSSS spreader and its output buffer.
package dsss_pkg;

  // Gold code length: one data bit is spread over this many chips.
  localparam int GOLD_N = 63;

  typedef enum logic {
    IDLE   = 1'b0,
    SPREAD = 1'b1
  } spr_state_e;

  // One spread chip plus its end-of-symbol marker.
  typedef struct packed {
    logic chip;
    logic last;
  } chip_beat_t;

endpackage

// File: rtl/dsss_spreader_skid.sv
// chip_skid_buf: output register plus a one-entry skid, valid/ready on both
// sides. The skid absorbs a beat that arrives while the output register is
// held by downstream backpressure; it always drains into the output register
// before any new beat, so beat order is preserved.
module chip_skid_buf
  import dsss_pkg::*;
(
  input  logic       clkin,
  input  logic       rstn,
  input  chip_beat_t in_beat,
  input  logic       in_valid,
  output logic       in_ready,
  output chip_beat_t out_beat,
  output logic       out_valid,
  input  logic       out_ready
);

  chip_beat_t skid_beat;
  logic       skid_valid;
  logic       out_free;

  // Room exists for an incoming beat whenever the skid is empty.
  assign in_ready = !skid_valid;
  // The output register can take a new beat if empty or being drained now.
  assign out_free = !out_valid || out_ready;

  // Output register and skid update; skid content has priority for the output.
  always_ff @(posedge clkin) begin
    if (rstn) begin
      out_valid  <= 1'b0;
      out_beat   <= '0;
      skid_valid <= 1'b0;
      skid_beat  <= '0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_beat   <= skid_beat;
        out_valid  <= 1'b1;
        skid_valid <= in_valid;
        if (in_valid) begin
          skid_beat <= in_beat;
        end
      end else begin
        out_valid <= in_valid;
        if (in_valid) begin
          out_beat <= in_beat;
        end
      end
    end else if (in_valid) begin
      skid_beat  <= in_beat;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/dsss_spreader.sv
// dsss_spreader: takes one data bit per symbol, requests N Gold chips from
// the code generator, XORs each with the held bit and streams the result out
// with full backpressure.
//
// Handshake rule on every interface: a transfer happens in the cycle where
// valid and ready are both high; valid never depends on ready.
// The generator is the exception: a request (code_req_o) is always answered
// one cycle later and cannot be stalled, so a credit counter reserves one of
// the two storage slots (output register + skid) before each request.
// The generator phase is never touched here, so the code runs on across
// symbols and across a reset of this block.
module dsss_spreader
  import dsss_pkg::*;
#(
  parameter int N     = GOLD_N,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic clkin,
  input  logic rstn,
  input  logic s_data_i,
  input  logic s_valid_i,
  output logic s_ready_o,
  input  logic code_chip_i,
  input  logic code_rdy_i,
  output logic code_req_o,
  output logic chip_o,
  output logic chip_valid_o,
  output logic chip_last_o,
  input  logic m_ready_i,
  output logic busy_o
);

  localparam logic [CNT_W-1:0] CNT_N    = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  spr_state_e       state;
  logic             data_bit;
  logic [CNT_W-1:0] req_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic [1:0]       credits;
  logic             inflight;
  logic             inflight_last;

  logic             s_fire;
  logic             out_fire;
  logic             credit_ok;
  logic             skid_in_ready;
  logic             skid_in_valid;
  logic             skid_out_valid;
  chip_beat_t       skid_in_beat;
  chip_beat_t       skid_out_beat;

  // Every output is forced low while reset is asserted so nothing leaks out
  // of a symbol that is being discarded.
  assign s_ready_o    = !rstn && (state == IDLE) && code_rdy_i;
  assign s_fire       = s_valid_i && s_ready_o;
  assign chip_valid_o = !rstn && skid_out_valid;
  assign chip_o       = !rstn && skid_out_beat.chip;
  assign chip_last_o  = chip_valid_o && skid_out_beat.last;
  assign busy_o       = !rstn && (state != IDLE);
  assign out_fire     = chip_valid_o && m_ready_i;

  // A slot emptied by this cycle's output handshake is already usable.
  assign credit_ok  = (credits != 2'd0) || out_fire;
  assign code_req_o = !rstn && (state == SPREAD) && (req_cnt < CNT_N) &&
                      code_rdy_i && credit_ok;

  // The chip returned this cycle answers last cycle's request.
  assign skid_in_valid = inflight && skid_in_ready;
  assign skid_in_beat  = '{chip: code_chip_i ^ data_bit, last: inflight_last};

  // Symbol FSM, bit latch, chip counters, in-flight tracking and credits.
  always_ff @(posedge clkin) begin
    if (rstn) begin
      state         <= IDLE;
      data_bit      <= 1'b0;
      req_cnt       <= '0;
      out_cnt       <= '0;
      credits       <= 2'd2;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= code_req_o;
      inflight_last <= code_req_o && (req_cnt == CNT_LAST);
      credits       <= credits + {1'b0, out_fire} - {1'b0, code_req_o};
      case (state)
        IDLE: begin
          if (s_fire) begin
            data_bit <= s_data_i;
            req_cnt  <= '0;
            out_cnt  <= '0;
            state    <= SPREAD;
          end
        end
        SPREAD: begin
          if (code_req_o) begin
            req_cnt <= req_cnt + 1'b1;
          end
          if (out_fire) begin
            out_cnt <= out_cnt + 1'b1;
            if (out_cnt == CNT_LAST) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  chip_skid_buf u_skid (
    .clkin     (clkin),
    .rstn      (rstn),
    .in_beat   (skid_in_beat),
    .in_valid  (skid_in_valid),
    .in_ready  (skid_in_ready),
    .out_beat  (skid_out_beat),
    .out_valid (skid_out_valid),
    .out_ready (m_ready_i)
  );

endmodule

// File: tb/tb_dsss_spreader.sv
// Bench for dsss_spreader: a one-cycle-latency Gold generator model, a
// monitor that captures output handshakes, and one task per scenario.
module tb_dsss_spreader;
  import dsss_pkg::*;

  localparam int N = GOLD_N;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  logic s_data_i    = 1'b0;
  logic s_valid_i   = 1'b0;
  logic s_ready_o;
  logic code_chip_i = 1'b0;
  logic code_rdy_i  = 1'b1;
  logic code_req_o;
  logic chip_o;
  logic chip_valid_o;
  logic chip_last_o;
  logic m_ready_i   = 1'b1;
  logic busy_o;

  dsss_spreader dut (
    .clkin        (clk),
    .rstn         (rstn),
    .s_data_i     (s_data_i),
    .s_valid_i    (s_valid_i),
    .s_ready_o    (s_ready_o),
    .code_chip_i  (code_chip_i),
    .code_rdy_i   (code_rdy_i),
    .code_req_o   (code_req_o),
    .chip_o       (chip_o),
    .chip_valid_o (chip_valid_o),
    .chip_last_o  (chip_last_o),
    .m_ready_i    (m_ready_i),
    .busy_o       (busy_o)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- generator model ----------------
  logic gold [N];
  int   gen_idx = 0;
  always @(posedge clk) begin
    if (code_req_o) begin
      code_chip_i <= gold[gen_idx];
      gen_idx     <= (gen_idx == N - 1) ? 0 : gen_idx + 1;
    end
  end

  // ---------------- monitor / capture ----------------
  logic got_chip [$];
  logic got_last [$];
  int   got_cyc [$];
  int   in_hs_cyc [$];
  int   stall_viol    = 0;
  int   credit_viol   = 0;
  int   busy_rdy_viol = 0;
  int   outst         = 0;
  logic prev_stall    = 1'b0;
  logic prev_chip     = 1'b0;
  logic prev_last     = 1'b0;
  logic after_last    = 1'b0;
  logic rdy_after_last = 1'b0;

  always @(negedge clk) begin
    #2;
    if (s_valid_i && s_ready_o) in_hs_cyc.push_back(cyc);
    if ((busy_o || chip_valid_o) && s_ready_o) busy_rdy_viol++;
    if (prev_stall && !rstn) begin
      if (!chip_valid_o || chip_o !== prev_chip || chip_last_o !== prev_last)
        stall_viol++;
    end
    prev_stall = chip_valid_o && !m_ready_i;
    prev_chip  = chip_o;
    prev_last  = chip_last_o;
    if (after_last) begin
      rdy_after_last = s_ready_o;
      after_last     = 1'b0;
    end
    if (chip_valid_o && m_ready_i) begin
      got_chip.push_back(chip_o);
      got_last.push_back(chip_last_o);
      got_cyc.push_back(cyc);
      if (chip_last_o) after_last = 1'b1;
    end
    if (rstn) outst = 0;
    else begin
      outst = outst + int'(code_req_o) - int'(chip_valid_o && m_ready_i);
      if (outst > 2 || outst < 0) credit_viol++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_capture();
    got_chip.delete();
    got_last.delete();
    got_cyc.delete();
    in_hs_cyc.delete();
    stall_viol     = 0;
    credit_viol    = 0;
    busy_rdy_viol  = 0;
    prev_stall     = 1'b0;
    after_last     = 1'b0;
    rdy_after_last = 1'b0;
  endtask

  task automatic send_bit(input logic b, output int phase, output int hs_cyc, output bit ok);
    ok = 1'b0;
    phase = 0;
    hs_cyc = 0;
    @(negedge clk);
    s_valid_i = 1'b1;
    s_data_i  = b;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (s_ready_o) begin
        ok = 1'b1;
        phase = gen_idx;
        hs_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    s_valid_i = 1'b0;
  endtask

  task automatic wait_chips(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #3;
      if (got_chip.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic int count_bad(input int p0, input int first, input int n, input logic b);
    int bad = 0;
    for (int k = first; k < first + n && k < got_chip.size(); k++)
      if (got_chip[k] !== (gold[(p0 + k) % N] ^ b)) bad++;
    return bad;
  endfunction

  function automatic int count_last();
    int c = 0;
    foreach (got_last[k]) if (got_last[k]) c++;
    return c;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (s_ready_o !== 1'b0) begin fails++; $display("FAIL reset_s_ready: got %b want 0", s_ready_o); end
    checks++; if (code_req_o !== 1'b0) begin fails++; $display("FAIL reset_code_req: got %b want 0", code_req_o); end
    checks++; if (chip_valid_o !== 1'b0) begin fails++; $display("FAIL reset_chip_valid: got %b want 0", chip_valid_o); end
    checks++; if (chip_o !== 1'b0) begin fails++; $display("FAIL reset_chip: got %b want 0", chip_o); end
    checks++; if (chip_last_o !== 1'b0) begin fails++; $display("FAIL reset_chip_last: got %b want 0", chip_last_o); end
    checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++; if (s_ready_o !== 1'b1) begin fails++; $display("FAIL idle_s_ready: got %b want 1", s_ready_o); end
  endtask

  task automatic test_spread_zero();
    int p0, hc, lat, span;
    bit ok;
    clear_capture();
    send_bit(1'b0, p0, hc, ok);
    checks++; if (ok !== 1'b1) begin fails++; $display("FAIL zero_accept: got %b want 1", ok); end
    wait_chips(N, 200, ok);
    repeat (4) @(negedge clk);
    #3;
    checks++; if (got_chip.size() !== N) begin fails++; $display("FAIL zero_count: got %0d want %0d", got_chip.size(), N); end
    checks++; if (count_bad(p0, 0, N, 1'b0) !== 0) begin fails++; $display("FAIL zero_chips: got %0d bad want 0", count_bad(p0, 0, N, 1'b0)); end
    lat  = (got_cyc.size() > 0) ? got_cyc[0] - hc : -1;
    span = (got_cyc.size() >= N) ? got_cyc[N-1] - got_cyc[0] : -1;
    checks++; if (lat !== 3) begin fails++; $display("FAIL zero_latency: got %0d want 3", lat); end
    checks++; if (span !== N - 1) begin fails++; $display("FAIL zero_throughput: got %0d want %0d", span, N - 1); end
    checks++; if (count_last() !== 1) begin fails++; $display("FAIL zero_last_count: got %0d want 1", count_last()); end
    checks++; if (got_last.size() < N || got_last[N-1] !== 1'b1) begin fails++; $display("FAIL zero_last_pos: got size %0d want last on chip %0d", got_last.size(), N); end
    checks++; if (credit_viol !== 0) begin fails++; $display("FAIL zero_credit: got %0d want 0", credit_viol); end
  endtask

  task automatic test_spread_one();
    int p0, hc;
    bit ok;
    clear_capture();
    send_bit(1'b1, p0, hc, ok);
    checks++; if (ok !== 1'b1) begin fails++; $display("FAIL one_accept: got %b want 1", ok); end
    wait_chips(N, 200, ok);
    repeat (4) @(negedge clk);
    #3;
    checks++; if (got_chip.size() !== N) begin fails++; $display("FAIL one_count: got %0d want %0d", got_chip.size(), N); end
    checks++; if (count_bad(p0, 0, N, 1'b1) !== 0) begin fails++; $display("FAIL one_chips: got %0d bad want 0", count_bad(p0, 0, N, 1'b1)); end
    checks++; if (busy_rdy_viol !== 0) begin fails++; $display("FAIL one_ready_in_spread: got %0d want 0", busy_rdy_viol); end
    checks++; if (rdy_after_last !== 1'b1) begin fails++; $display("FAIL one_ready_after_last: got %b want 1", rdy_after_last); end
  endtask

  task automatic test_backpressure();
    int p0, hc;
    bit ok;
    clear_capture();
    send_bit(1'b1, p0, hc, ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      m_ready_i = (i >= 20 && i < 25) ? 1'b0 : ((i % 2) == 0);
      #3;
      if (got_chip.size() >= N) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
    m_ready_i = 1'b1;
    repeat (4) @(negedge clk);
    #3;
    checks++; if (got_chip.size() !== N) begin fails++; $display("FAIL bp_count: got %0d want %0d", got_chip.size(), N); end
    checks++; if (count_bad(p0, 0, N, 1'b1) !== 0) begin fails++; $display("FAIL bp_chips: got %0d bad want 0", count_bad(p0, 0, N, 1'b1)); end
    checks++; if (stall_viol !== 0) begin fails++; $display("FAIL bp_stable: got %0d changes want 0", stall_viol); end
    checks++; if (credit_viol !== 0) begin fails++; $display("FAIL bp_credit: got %0d want 0", credit_viol); end
    checks++; if (got_last.size() < N || got_last[N-1] !== 1'b1 || count_last() !== 1) begin fails++; $display("FAIL bp_last: got %0d lasts want 1 on chip %0d", count_last(), N); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] bits;
    int p0, nhs, bad, gap0, gap1;
    bit ok;
    bits = 3'b101;
    nhs = 0;
    p0 = 0;
    bad = 0;
    clear_capture();
    @(negedge clk);
    s_valid_i = 1'b1;
    s_data_i  = bits[0];
    for (int i = 0; i < 400 && nhs < 3; i++) begin
      #1;
      if (s_ready_o) begin
        if (nhs == 0) p0 = gen_idx;
        nhs++;
      end
      @(negedge clk);
      if (nhs < 3) s_data_i = bits[nhs];
      else s_valid_i = 1'b0;
    end
    s_valid_i = 1'b0;
    wait_chips(3 * N, 400, ok);
    repeat (4) @(negedge clk);
    #3;
    for (int k = 0; k < got_chip.size() && k < 3 * N; k++)
      if (got_chip[k] !== (gold[(p0 + k) % N] ^ bits[k / N])) bad++;
    gap0 = (in_hs_cyc.size() >= 2) ? in_hs_cyc[1] - in_hs_cyc[0] : -1;
    gap1 = (in_hs_cyc.size() >= 3) ? in_hs_cyc[2] - in_hs_cyc[1] : -1;
    checks++; if (got_chip.size() !== 3 * N) begin fails++; $display("FAIL b2b_count: got %0d want %0d", got_chip.size(), 3 * N); end
    checks++; if (bad !== 0) begin fails++; $display("FAIL b2b_chips: got %0d bad want 0", bad); end
    checks++; if (in_hs_cyc.size() !== 3) begin fails++; $display("FAIL b2b_accepts: got %0d want 3", in_hs_cyc.size()); end
    checks++; if (gap0 !== N + 3) begin fails++; $display("FAIL b2b_gap0: got %0d want %0d", gap0, N + 3); end
    checks++; if (gap1 !== N + 3) begin fails++; $display("FAIL b2b_gap1: got %0d want %0d", gap1, N + 3); end
    checks++; if (count_last() !== 3 || got_last.size() < 3 * N || !got_last[N-1] || !got_last[2*N-1] || !got_last[3*N-1]) begin fails++; $display("FAIL b2b_last: got %0d lasts want 3 at symbol ends", count_last()); end
  endtask

  task automatic test_reset_mid();
    int p0, hc;
    bit ok;
    clear_capture();
    send_bit(1'b1, p0, hc, ok);
    wait_chips(20, 200, ok);
    checks++; if (ok !== 1'b1) begin fails++; $display("FAIL rst_reach20: got %b want 1", ok); end
    @(negedge clk);
    rstn = 1'b1;
    clear_capture();
    #1;
    checks++; if (s_ready_o !== 1'b0 || code_req_o !== 1'b0 || chip_valid_o !== 1'b0) begin fails++; $display("FAIL rst_during: got rdy=%b req=%b vld=%b want 000", s_ready_o, code_req_o, chip_valid_o); end
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++; if (chip_valid_o !== 1'b0 || chip_o !== 1'b0 || chip_last_o !== 1'b0) begin fails++; $display("FAIL rst_after_chip: got vld=%b chip=%b last=%b want 000", chip_valid_o, chip_o, chip_last_o); end
    checks++; if (code_req_o !== 1'b0 || busy_o !== 1'b0) begin fails++; $display("FAIL rst_after_ctl: got req=%b busy=%b want 00", code_req_o, busy_o); end
    repeat (5) @(negedge clk);
    #3;
    checks++; if (got_chip.size() !== 0) begin fails++; $display("FAIL rst_no_partial: got %0d chips want 0", got_chip.size()); end
    send_bit(1'b0, p0, hc, ok);
    wait_chips(N, 200, ok);
    repeat (4) @(negedge clk);
    #3;
    checks++; if (got_chip.size() !== N) begin fails++; $display("FAIL rst_next_count: got %0d want %0d", got_chip.size(), N); end
    checks++; if (count_bad(p0, 0, N, 1'b0) !== 0) begin fails++; $display("FAIL rst_next_chips: got %0d bad want 0", count_bad(p0, 0, N, 1'b0)); end
    checks++; if (count_last() !== 1) begin fails++; $display("FAIL rst_next_last: got %0d want 1", count_last()); end
  endtask

  task automatic test_code_rdy();
    int p0, hc, seen_rdy, seen_req;
    bit ok;
    seen_rdy = 0;
    seen_req = 0;
    clear_capture();
    @(negedge clk);
    code_rdy_i = 1'b0;
    s_valid_i  = 1'b1;
    s_data_i   = 1'b1;
    repeat (5) begin
      #1;
      if (s_ready_o) seen_rdy++;
      @(negedge clk);
    end
    code_rdy_i = 1'b1;
    s_valid_i  = 1'b0;
    #3;
    checks++; if (seen_rdy !== 0) begin fails++; $display("FAIL crdy_idle_ready: got %0d want 0", seen_rdy); end
    checks++; if (in_hs_cyc.size() !== 0) begin fails++; $display("FAIL crdy_idle_accept: got %0d want 0", in_hs_cyc.size()); end
    send_bit(1'b1, p0, hc, ok);
    wait_chips(10, 100, ok);
    @(negedge clk);
    code_rdy_i = 1'b0;
    repeat (4) begin
      #1;
      if (code_req_o) seen_req++;
      @(negedge clk);
    end
    code_rdy_i = 1'b1;
    checks++; if (seen_req !== 0) begin fails++; $display("FAIL crdy_spread_req: got %0d want 0", seen_req); end
    wait_chips(N, 200, ok);
    repeat (4) @(negedge clk);
    #3;
    checks++; if (got_chip.size() !== N) begin fails++; $display("FAIL crdy_count: got %0d want %0d", got_chip.size(), N); end
    checks++; if (count_bad(p0, 0, N, 1'b1) !== 0) begin fails++; $display("FAIL crdy_chips: got %0d bad want 0", count_bad(p0, 0, N, 1'b1)); end
    checks++; if (credit_viol !== 0) begin fails++; $display("FAIL crdy_credit: got %0d want 0", credit_viol); end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence and report ----------------
  initial begin
    logic [5:0] ra, rb;
    ra = 6'b000001;
    rb = 6'b100001;
    for (int i = 0; i < N; i++) begin
      gold[i] = ra[0] ^ rb[0];
      ra = {ra[0] ^ ra[1], ra[5:1]};
      rb = {rb[0] ^ rb[1] ^ rb[4] ^ rb[5], rb[5:1]};
    end
    test_reset();
    test_spread_zero();
    test_spread_one();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_code_rdy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
